// File: rtl/lcd_sequencer.sv
// HD44780-style LCD sequencer: power-up delay, fixed init sequence, then runs an
// external command table on request with per-transfer setup/enable/post-wait timing.
module lcd_sequencer #(
  parameter int unsigned T_PWRUP  = 750000,
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_EN     = 12,
  parameter int unsigned T_CMD    = 2000,
  parameter int unsigned T_CLR    = 82000,
  parameter int unsigned T_WAIT2  = 100000000,
  parameter int unsigned LAST_IDX = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] cmd_data,
  output logic [31:0] cmd_idx,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_db,
  output logic        busy,
  output logic        done,
  output logic [3:0]  dbg_state
);

  // A zero delay parameter still costs one cycle in its state.
  localparam logic [31:0] L_PWRUP = (T_PWRUP == 0) ? 32'd1 : 32'(T_PWRUP);
  localparam logic [31:0] L_SETUP = (T_SETUP == 0) ? 32'd1 : 32'(T_SETUP);
  localparam logic [31:0] L_EN    = (T_EN    == 0) ? 32'd1 : 32'(T_EN);
  localparam logic [31:0] L_CMD   = (T_CMD   == 0) ? 32'd1 : 32'(T_CMD);
  localparam logic [31:0] L_CLR   = (T_CLR   == 0) ? 32'd1 : 32'(T_CLR);
  localparam logic [31:0] L_WAIT2 = (T_WAIT2 == 0) ? 32'd1 : 32'(T_WAIT2);
  localparam logic [31:0] L_LAST  = 32'(LAST_IDX);

  typedef enum logic [3:0] {
    S_PWRUP, S_INIT, S_IDLE, S_FETCH, S_SETUP, S_EN_HI, S_WAIT, S_HOLD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] idx_q, idx_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic [7:0]  db_q, db_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  op_q, op_d;
  logic        in_init_q, in_init_d;
  logic [2:0]  init_cnt_q, init_cnt_d;
  logic        expired;
  logic        advance;

  function automatic logic [7:0] init_byte(input logic [2:0] k);
    case (k)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h0C;
      3'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  // DDRAM address: line 1 for 0..39, line 2 for 40..79, out of range clamps home.
  function automatic logic [7:0] setad_byte(input logic [7:0] arg);
    if (arg < 8'd40)      setad_byte = 8'h80 | arg;
    else if (arg < 8'd80) setad_byte = 8'hC0 | (arg - 8'd40);
    else                  setad_byte = 8'h80;
  endfunction

  assign expired = (cnt_q <= 32'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - 32'd1;
    idx_d      = idx_q;
    rs_d       = rs_q;
    en_d       = en_q;
    db_d       = db_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    op_d       = op_q;
    in_init_d  = in_init_q;
    init_cnt_d = init_cnt_q;
    advance    = 1'b0;

    case (state_q)
      S_PWRUP: if (expired) begin
        rs_d       = 1'b0;
        db_d       = init_byte(3'd0);
        init_cnt_d = 3'd1;
        in_init_d  = 1'b1;
        cnt_d      = L_SETUP;
        state_d    = S_SETUP;
      end
      S_INIT: if (init_cnt_q == 3'd4) begin
        in_init_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end else begin
        rs_d       = 1'b0;
        db_d       = init_byte(init_cnt_q);
        init_cnt_d = init_cnt_q + 3'd1;
        cnt_d      = L_SETUP;
        state_d    = S_SETUP;
      end
      S_IDLE: if (start) begin
        idx_d   = 32'd0;
        busy_d  = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        op_d = cmd_data[11:8];
        case (cmd_data[11:8])
          4'h0: begin rs_d = 1'b0; db_d = 8'h01; cnt_d = L_SETUP; state_d = S_SETUP; end
          4'h1: begin rs_d = 1'b1; db_d = cmd_data[7:0]; cnt_d = L_SETUP; state_d = S_SETUP; end
          4'h3: begin
            rs_d    = 1'b0;
            db_d    = setad_byte(cmd_data[7:0]);
            cnt_d   = L_SETUP;
            state_d = S_SETUP;
          end
          4'h4:    begin cnt_d = L_WAIT2; state_d = S_HOLD; end
          default: advance = 1'b1;
        endcase
      end
      S_SETUP: if (expired) begin
        en_d    = 1'b1;
        cnt_d   = L_EN;
        state_d = S_EN_HI;
      end
      S_EN_HI: if (expired) begin
        en_d = 1'b0;
        // Clear is the only slow instruction, both during init and from the table.
        if (in_init_q) cnt_d = (db_q == 8'h01) ? L_CLR : L_CMD;
        else           cnt_d = (op_q == 4'h0) ? L_CLR : L_CMD;
        state_d = S_WAIT;
      end
      S_WAIT: if (expired) begin
        if (in_init_q) state_d = S_INIT;
        else           advance = 1'b1;
      end
      S_HOLD: if (expired) advance = 1'b1;
      S_DONE: begin
        idx_d   = 32'd0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_PWRUP;
    endcase

    if (advance) begin
      if (idx_q == L_LAST) begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 32'd1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_PWRUP;
      cnt_q      <= L_PWRUP;
      idx_q      <= 32'd0;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      db_q       <= 8'h00;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      op_q       <= 4'h0;
      in_init_q  <= 1'b0;
      init_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      db_q       <= db_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      op_q       <= op_d;
      in_init_q  <= in_init_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign cmd_idx   = idx_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = en_q;
  assign lcd_db    = db_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
